// File: rtl/fifo_wr_pkg.sv
// Shared types and helpers for the FIFO write-side burst producer.
package fifo_wr_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    WRITE      = 2'd2,
    DONE       = 2'd3
  } wr_state_e;

  function automatic int depth_of(input int ptr_size);
    return 1 << (ptr_size - 1);
  endfunction

  // Callers zero-extend narrower pointers; the upper result bits stay zero.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int i = 1; i < 32; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_burst_writer_if.sv
// Burst request, upstream stream and FIFO write-port signals of the burst writer.
interface fifo_burst_writer_if #(
  parameter int PTR_SIZE = 4,
  parameter int DATA_W   = 8
);
  logic                burst_req;
  logic [PTR_SIZE-1:0] burst_len;
  logic                burst_ack;
  logic                burst_done;
  logic                burst_err;
  logic                s_valid;
  logic [DATA_W-1:0]   s_data;
  logic                s_ready;
  logic [PTR_SIZE-1:0] gray_wr_ptr;
  logic [PTR_SIZE-1:0] rd_gray_ptr;
  logic                wfull;
  logic                winc;
  logic [DATA_W-1:0]   wdata;

  modport slave (
    input  burst_req, burst_len, s_valid, s_data, gray_wr_ptr, rd_gray_ptr, wfull,
    output burst_ack, burst_done, burst_err, s_ready, winc, wdata
  );

  modport master (
    output burst_req, burst_len, s_valid, s_data, gray_wr_ptr, rd_gray_ptr, wfull,
    input  burst_ack, burst_done, burst_err, s_ready, winc, wdata
  );
endinterface

// File: rtl/fifo_rptr_sync.sv
// Two-flop synchroniser for a gray-coded FIFO pointer, presented as binary.
module fifo_rptr_sync
  import fifo_wr_pkg::*;
#(
  parameter int PTR_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PTR_SIZE-1:0] gray_i,
  output logic [PTR_SIZE-1:0] bin_o
);
  logic [PTR_SIZE-1:0] wq1_q;
  logic [PTR_SIZE-1:0] wq2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wq1_q <= '0;
      wq2_q <= '0;
    end else begin
      wq1_q <= gray_i;
      wq2_q <= wq1_q;
    end
  end

  assign bin_o = PTR_SIZE'(gray2bin(32'(wq2_q)));
endmodule

// File: rtl/fifo_burst_writer.sv
// Drives the async FIFO write port in unsplit bursts once the whole burst fits.
// Define FIFO_WR_LEVEL_EN to add the registered wlevel / walmost_full outputs.
module fifo_burst_writer
  import fifo_wr_pkg::*;
#(
  parameter int PTR_SIZE = 4,
  parameter int DATA_W   = 8
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  fifo_burst_writer_if.slave   bus
`ifdef FIFO_WR_LEVEL_EN
  ,
  output logic [PTR_SIZE-1:0]  wlevel,
  output logic                 walmost_full
`endif
);
  localparam logic [PTR_SIZE-1:0] DEPTH = PTR_SIZE'(depth_of(PTR_SIZE));

  wr_state_e           state_q, state_d;
  logic [PTR_SIZE-1:0] remaining_q, remaining_d;
  logic [PTR_SIZE-1:0] rbin, wbin, used, free;
  logic                write_fire;

  fifo_rptr_sync #(.PTR_SIZE(PTR_SIZE)) u_rptr_sync (
    .clk    (wclk),
    .rst_n  (wrst_n),
    .gray_i (bus.rd_gray_ptr),
    .bin_o  (rbin)
  );

  assign wbin = PTR_SIZE'(gray2bin(32'(bus.gray_wr_ptr)));
  assign used = wbin - rbin;
  assign free = DEPTH - used;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  assign write_fire = (state_q == WRITE) && bus.s_valid && !bus.wfull;

  // Request strobes are qualified with wrst_n so nothing pulses while reset is held.
  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    bus.burst_ack  = 1'b0;
    bus.burst_err  = 1'b0;
    bus.burst_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.burst_req && wrst_n) begin
          if (bus.burst_len == '0) begin
            bus.burst_ack = 1'b1;
            state_d       = DONE;
          end else if (bus.burst_len > DEPTH) begin
            bus.burst_err = 1'b1;
          end else begin
            bus.burst_ack = 1'b1;
            remaining_d   = bus.burst_len;
            state_d       = WAIT_SPACE;
          end
        end
      end
      WAIT_SPACE: begin
        if (free >= remaining_q) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (write_fire) begin
          remaining_d = remaining_q - PTR_SIZE'(1);
          if (remaining_q == PTR_SIZE'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        bus.burst_done = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.winc    = write_fire;
  assign bus.s_ready = write_fire;
  assign bus.wdata   = DATA_W'(bus.s_data);

`ifdef FIFO_WR_LEVEL_EN
  logic [PTR_SIZE-1:0] wlevel_q;
  logic                walmost_full_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel_q       <= '0;
      walmost_full_q <= 1'b0;
    end else begin
      wlevel_q       <= used;
      walmost_full_q <= (used >= (DEPTH - PTR_SIZE'(2)));
    end
  end

  assign wlevel       = wlevel_q;
  assign walmost_full = walmost_full_q;
`endif
endmodule

// File: doc/fifo_burst_writer.md
Name: fifo_burst_writer

Overview:
- Write-domain producer that drives the write port of the team's asynchronous FIFO: it generates winc and wdata from an upstream valid/ready stream.
- Accepts a burst request of N words and starts writing only when the FIFO has room for all N, so bursts are never split by wfull back-pressure.
- Synchronises the read-domain gray pointer into wclk and derives the free-slot count.
- Sits between the packet source and the FIFO write side, entirely in the wclk domain.

Parameters:
- PTR_SIZE, 4, pointer width including wrap bit; FIFO DEPTH = 2^(PTR_SIZE-1) (8 at default).
- DATA_W, 8, FIFO data width.

Ports:
- wclk  in  1  write-domain clock.
- wrst_n  in  1  asynchronous active-low reset.
- burst_req  in  1  level request; held until burst_ack.
- burst_len  in  PTR_SIZE  words in burst; sampled at acceptance.
- burst_ack  out  1  one-cycle pulse, burst accepted.
- burst_done  out  1  one-cycle pulse after the last word is written.
- burst_err  out  1  one-cycle pulse, burst_len > DEPTH rejected.
- s_valid  in  1  upstream word valid.
- s_data  in  DATA_W  upstream word.
- s_ready  out  1  upstream word consumed this cycle.
- gray_wr_ptr  in  PTR_SIZE  FIFO gray write pointer (wclk domain).
- rd_gray_ptr  in  PTR_SIZE  FIFO gray read pointer, raw, from the read domain.
- wfull  in  1  FIFO full flag.
- winc  out  1  FIFO write enable.
- wdata  out  DATA_W  FIFO write data.

Behaviour:
- Reset (async, wrst_n low): state IDLE, sync flops 0, remaining count 0, burst_ack/burst_done/burst_err 0. winc and s_ready are 0 because state is IDLE.
- Synchroniser: rd_gray_ptr passes through 2 flops (wq1, wq2) on wclk; no other logic between the flops. Latency is 2 wclk.
- Pointer arithmetic:
  - rbin = gray2bin(wq2); wbin = gray2bin(gray_wr_ptr).
  - used = (wbin - rbin) mod 2^PTR_SIZE; free = DEPTH - used.
  - All arithmetic is PTR_SIZE bits with unsigned wrap.
- FSM states IDLE, WAIT_SPACE, WRITE, DONE:
  - IDLE, burst_req=1:
    - burst_len == 0: pulse burst_ack, go to DONE.
    - burst_len > DEPTH: pulse burst_err, no ack, stay in IDLE. The requester must drop burst_req.
    - Otherwise: latch remaining = burst_len, pulse burst_ack, go to WAIT_SPACE.
  - WAIT_SPACE: when free >= remaining, go to WRITE next cycle. Stale wq2 only under-estimates free space, so the check is conservative.
  - WRITE:
    - winc = s_ready = s_valid && !wfull (combinational from registered state); wdata = s_data.
    - Each winc decrements remaining.
    - When winc fires with remaining == 1, go to DONE.
    - s_valid low mid-burst: stall in WRITE with no timeout.
    - wfull high mid-burst (should not occur): hold winc low, keep waiting.
  - DONE: burst_done = 1 for exactly one cycle, then IDLE. A new burst_req is not accepted in DONE.
- Outside WRITE: winc = 0, s_ready = 0.
- Handshake timing:
  - burst_ack is high during the acceptance cycle (combinational with the IDLE transition); the requester may change burst_len the cycle after.
  - Minimum burst latency with space available: ack at cycle 0, WAIT_SPACE at 1, WRITE at 2, first winc at 2.
- Wrap-around: pointers wrap modulo 2^PTR_SIZE; used is correct across the wrap, e.g. wbin=1, rbin=13 gives used=4.
- Reset mid-burst returns to IDLE with no burst_done. Words already written stay in the FIFO.

Optional Feature:
- FIFO_WR_LEVEL_EN defined:
  - Adds output wlevel [PTR_SIZE-1:0], the registered `used` value, reset 0, updated every cycle.
  - Adds output walmost_full, registered, high when used >= DEPTH-2.
- Undefined: neither port exists and there is no extra logic.

Decomposition:
- Package fifo_wr_pkg:
  - state enum (IDLE, WAIT_SPACE, WRITE, DONE).
  - DEPTH-from-PTR_SIZE function.
  - gray2bin function.
- One sub-module, fifo_rptr_sync: 2-flop gray synchroniser with binary output. Reused later by the read side for the write pointer.

Test Plan:
- Reset: hold wrst_n low, toggle inputs -> winc=0, s_ready=0, all pulses 0. Release: state IDLE.
- Empty FIFO (both pointers 0), burst_len=5, s_valid always 1, s_data=0xA0..0xA4 -> ack at cycle 0, winc on cycles 2-6 with wdata 0xA0..0xA4, burst_done at cycle 7.
- used=6 (DEPTH 8), burst_len=4 -> stays in WAIT_SPACE with winc=0. Advance rd_gray_ptr by 2 -> WRITE entered exactly 3 cycles after the pointer change (2-flop sync + 1).
- burst_len=9 -> burst_err pulse, no ack, no winc. burst_len=0 -> ack then burst_done, zero writes.
- Wrap: wbin=1, rbin=13 (used 4), burst_len=4 -> proceeds to WRITE. burst_len=5 -> waits.
- Mid-burst s_valid gap of 3 cycles, then wrst_n asserted -> winc stalls during the gap; after reset returns to IDLE with no burst_done.
